// File: rtl/audio_note_sequencer.sv
// Tempo-driven 16-step note scheduler feeding the square-wave tone generator.
// Latency: note/octave/step/strobe register on the same edge the FSM enters NOTE; gate/busy decode from state.
// No backpressure: the sequencer free-runs on the tempo tick; enable low stops it on the next edge.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           1 = play, 0 = stop at the next edge
//   audio_select[1:0] pattern: 0 chromatic up, 1 chromatic down, 2 arpeggio, 3 silence
//   note[3:0]        semitone within octave (0..11)
//   octave[2:0]      octave index (0..5)
//   gate             tone generator should sound
//   note_strobe      one-cycle pulse when note/octave/step take a new value
//   step[3:0]        current pattern step
//   busy             sequencer is not idle
module audio_note_sequencer #(
    parameter int TICK_DIV   = 1500000,
    parameter int NOTE_TICKS = 8,
    parameter int GAP_TICKS  = 1,
    parameter int BASE_OCT   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] audio_select,
    output logic [3:0] note,
    output logic [2:0] octave,
    output logic       gate,
    output logic       note_strobe,
    output logic [3:0] step,
    output logic       busy
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int TCK_W = $clog2(NOTE_TICKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [TCK_W-1:0]   tcnt_q, tcnt_d;
    logic [3:0]         step_q, step_d;
    logic [3:0]         note_q, note_d;
    logic [2:0]         oct_q, oct_d;
    logic               strobe_q, strobe_d;

    logic               tick;
    logic [3:0]         entry_step;
    logic [4:0]         arp_base;
    logic [4:0]         semi;
    logic [3:0]         map_note;
    logic [1:0]         oct_inc;
    logic [3:0]         oct_sum;
    logic [2:0]         map_oct;

    assign tick = (div_q == DIV_W'(TICK_DIV - 1));

    // Step that the next NOTE entry will present: a fresh start from IDLE
    // always begins at step 0, otherwise advance (wrapping 15 -> 0).
    assign entry_step = (state_q == IDLE) ? 4'd0 : step_q + 4'd1;

    // Semitone for the entry step, using the live select since it is only
    // consumed at a note boundary.
    always_comb begin
        arp_base = 5'd0;
        semi     = 5'd0;
        case (entry_step[1:0])
            2'd0:    arp_base = 5'd0;
            2'd1:    arp_base = 5'd4;
            2'd2:    arp_base = 5'd7;
            default: arp_base = 5'd12;
        endcase
        case (audio_select)
            2'd0:    semi = {1'b0, entry_step};
            2'd1:    semi = {1'b0, 4'd15 - entry_step};
            default: semi = arp_base + (entry_step[2] ? 5'd12 : 5'd0);
        endcase
    end

    // Semitone range is 0..24, so two compare/subtract stages cover it.
    always_comb begin
        map_note = 4'd0;
        oct_inc  = 2'd0;
        if (semi >= 5'd24) begin
            map_note = 4'(semi - 5'd24);
            oct_inc  = 2'd2;
        end else if (semi >= 5'd12) begin
            map_note = 4'(semi - 5'd12);
            oct_inc  = 2'd1;
        end else begin
            map_note = semi[3:0];
            oct_inc  = 2'd0;
        end
        oct_sum = 4'(BASE_OCT) + {2'b00, oct_inc};
        map_oct = (oct_sum > 4'd5) ? 3'd5 : oct_sum[2:0];
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        tcnt_d   = tcnt_q;
        step_d   = step_q;
        note_d   = note_q;
        oct_d    = oct_q;
        strobe_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && audio_select != 2'd3) begin
                    state_d  = NOTE;
                    div_d    = '0;
                    tcnt_d   = '0;
                    step_d   = entry_step;
                    note_d   = map_note;
                    oct_d    = map_oct;
                    strobe_d = 1'b1;
                end
            end
            NOTE: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    if (tcnt_q == TCK_W'(NOTE_TICKS - GAP_TICKS - 1)) begin
                        state_d = GAP;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    if (tcnt_q == TCK_W'(GAP_TICKS - 1)) begin
                        tcnt_d = '0;
                        div_d  = '0;
                        if (audio_select == 2'd3) begin
                            state_d = IDLE;
                        end else begin
                            state_d  = NOTE;
                            step_d   = entry_step;
                            note_d   = map_note;
                            oct_d    = map_oct;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Stop overrides everything; displayed note/step are held.
        if (!enable) begin
            state_d  = IDLE;
            div_d    = '0;
            tcnt_d   = '0;
            step_d   = step_q;
            note_d   = note_q;
            oct_d    = oct_q;
            strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            tcnt_q   <= '0;
            step_q   <= 4'd0;
            note_q   <= 4'd0;
            oct_q    <= 3'd0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tcnt_q   <= tcnt_d;
            step_q   <= step_d;
            note_q   <= note_d;
            oct_q    <= oct_d;
            strobe_q <= strobe_d;
        end
    end

    assign note        = note_q;
    assign octave      = oct_q;
    assign step        = step_q;
    assign note_strobe = strobe_q;
    assign gate        = (state_q == NOTE);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_audio_note_sequencer.sv
module tb_audio_note_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] audio_select = 2'd0;
    logic [3:0] note;
    logic [2:0] octave;
    logic       gate;
    logic       note_strobe;
    logic [3:0] step;
    logic       busy;

    audio_note_sequencer #(
        .TICK_DIV  (4),
        .NOTE_TICKS(4),
        .GAP_TICKS (1),
        .BASE_OCT  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .audio_select(audio_select),
        .note        (note),
        .octave      (octave),
        .gate        (gate),
        .note_strobe (note_strobe),
        .step        (step),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stp;
        int nt;
        int oc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic push(input int s, input int n, input int o);
        exp_t e;
        e.stp = s;
        e.nt  = n;
        e.oc  = o;
        exp_q.push_back(e);
    endtask

    // Monitor: checks every presented note against the scoreboard, plus
    // strobe spacing and gate-high length within a continuous run.
    int  last_strobe = 0;
    bit  in_run      = 1'b0;
    int  gate_run    = 0;
    bit  gate_prev   = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (note_strobe) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe step=%0d note=%0d oct=%0d", step, note, octave);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_step", int'(step), e.stp);
                    chk("strobe_note", int'(note), e.nt);
                    chk("strobe_oct", int'(octave), e.oc);
                    chk("strobe_gate", int'(gate), 1);
                end
                if (in_run) chk("step_period", cyc - last_strobe, 16);
                in_run      = 1'b1;
                last_strobe = cyc;
            end
            if (!busy) in_run = 1'b0;
            if (gate) begin
                gate_run++;
            end else begin
                if (gate_prev && busy) chk("gate_high_len", gate_run, 12);
                gate_run = 0;
            end
            gate_prev = gate;
        end else begin
            in_run    = 1'b0;
            gate_run  = 0;
            gate_prev = 1'b0;
        end
    end

    task automatic wait_strobes(input int n);
        int seen = 0;
        int t    = 0;
        while (seen < n && t < n * 20 + 40) begin
            @(negedge clk);
            t++;
            if (note_strobe) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout actual=%0d expected=%0d", seen, n);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle_cycles(3);
        chk("rst_gate", int'(gate), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_note", int'(note), 0);
        chk("rst_oct", int'(octave), 0);
        chk("rst_strobe", int'(note_strobe), 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Chromatic up across the full pattern and the 15->0 wrap
        for (int s = 0; s < 16; s++) begin
            if (s < 12) push(s, s, 1);
            else        push(s, s - 12, 2);
        end
        push(0, 0, 1);
        audio_select = 2'd0;
        enable       = 1'b1;
        wait_strobes(17);

        // Stop mid-NOTE
        idle_cycles(3);
        chk("pre_stop_gate", int'(gate), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("stop_gate", int'(gate), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_hold_step", int'(step), 0);
        idle_cycles(2);

        // Chromatic down
        push(0, 3, 2);
        push(1, 2, 2);
        push(2, 1, 2);
        push(3, 0, 2);
        push(4, 11, 1);
        audio_select = 2'd1;
        enable       = 1'b1;
        wait_strobes(5);
        enable = 1'b0;
        idle_cycles(3);

        // Arpeggio
        push(0, 0, 1);
        push(1, 4, 1);
        push(2, 7, 1);
        push(3, 0, 2);
        push(4, 0, 2);
        push(5, 4, 2);
        push(6, 7, 2);
        push(7, 0, 3);
        audio_select = 2'd2;
        enable       = 1'b1;
        wait_strobes(8);
        enable = 1'b0;
        idle_cycles(3);

        // Select change mid-step takes effect only at the next boundary
        push(0, 0, 1);
        push(1, 1, 1);
        audio_select = 2'd0;
        enable       = 1'b1;
        wait_strobes(2);
        idle_cycles(5);
        audio_select = 2'd2;
        @(negedge clk);
        chk("midstep_note_hold", int'(note), 1);
        chk("midstep_step_hold", int'(step), 1);
        push(2, 7, 1);
        push(3, 0, 2);
        wait_strobes(2);

        // Silence at the boundary returns to IDLE, holding the last step
        audio_select = 2'd3;
        idle_cycles(18);
        chk("sel3_busy", int'(busy), 0);
        chk("sel3_gate", int'(gate), 0);
        chk("sel3_hold_step", int'(step), 3);
        chk("sel3_hold_note", int'(note), 0);
        enable = 1'b0;
        idle_cycles(2);

        // Async reset in the middle of GAP
        push(0, 3, 2);
        audio_select = 2'd1;
        enable       = 1'b1;
        wait_strobes(1);
        idle_cycles(13);
        chk("pre_rst_gate", int'(gate), 0);
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_note", int'(note), 0);
        chk("arst_oct", int'(octave), 0);
        chk("arst_step", int'(step), 0);
        chk("arst_gate", int'(gate), 0);
        enable = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
